// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus for the shift-and-add multiplier.
// master drives the request side; slave is the multiplier.
interface shift_add_multiplier_if;
   logic        iStart;
   logic [7:0]  iData_a;
   logic [7:0]  iData_b;
   logic        oBusy;
   logic        oDone;
   logic [15:0] oProduct;

   modport master (output iStart, iData_a, iData_b, input oBusy, oDone, oProduct);
   modport slave  (input iStart, iData_a, iData_b, output oBusy, oDone, oProduct);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around the 8-bit ripple-carry Adder.
// Optional early exit when no multiplier bits remain: define MUL_EARLY_EXIT_EN.
//
// state  | meaning
// IDLE   | waiting for iStart, operands captured on accept
// CALC   | one add/shift step per cycle, oBusy high
// DONE   | oDone pulse, oProduct just updated
module shift_add_multiplier (
   input logic                    iClk,
   input logic                    iRst_n,
   shift_add_multiplier_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state;
   logic [7:0]  a_reg;
   logic [7:0]  acc;
   logic [7:0]  q;
   logic [3:0]  cnt;
   logic [15:0] product;
   logic [7:0]  sum;
   logic        sum_c;
   logic [15:0] r_next;

   Adder u_adder (
      .iData_a (acc),
      .iData_b (a_reg),
      .iC      (1'b0),
      .oData   (sum),
      .oData_C (sum_c)
   );

   // The adder carry lands in bit 15 after the shift; dropping it breaks 255*255.
   always_comb begin
      r_next = {1'b0, acc, q[7:1]};
      if (q[0]) r_next = {sum_c, sum, q[7:1]};
   end

`ifdef MUL_EARLY_EXIT_EN
   logic [7:0]  m;
   logic [15:0] r_early;
   // With no multiplier bits left, R already holds product << (8 - cnt).
   assign r_early = {acc, q} >> (4'd8 - cnt);
`endif

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state   <= S_IDLE;
         a_reg   <= 8'h00;
         acc     <= 8'h00;
         q       <= 8'h00;
         cnt     <= 4'h0;
         product <= 16'h0000;
`ifdef MUL_EARLY_EXIT_EN
         m       <= 8'h00;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.iStart) begin
                  a_reg <= bus.iData_a;
                  acc   <= 8'h00;
                  q     <= bus.iData_b;
                  cnt   <= 4'h0;
`ifdef MUL_EARLY_EXIT_EN
                  m     <= bus.iData_b;
`endif
                  state <= S_CALC;
               end
            end
            S_CALC: begin
`ifdef MUL_EARLY_EXIT_EN
               if (m == 8'h00) begin
                  product <= r_early;
                  state   <= S_DONE;
               end else begin
                  m <= m >> 1;
`else
               begin
`endif
                  {acc, q} <= r_next;
                  cnt      <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     product <= r_next;
                     state   <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.oBusy    = (state == S_CALC);
   assign bus.oDone    = (state == S_DONE);
   assign bus.oProduct = product;
endmodule

module Adder (
   input  logic [7:0] iData_a,
   input  logic [7:0] iData_b,
   input  logic       iC,
   output logic [7:0] oData,
   output logic       oData_C
);
   logic [8:0] c;

   assign c[0] = iC;
   for (genvar i = 0; i < 8; i++) begin : g_fa
      FA u_fa (
         .iA (iData_a[i]),
         .iB (iData_b[i]),
         .iC (c[i]),
         .oS (oData[i]),
         .oC (c[i+1])
      );
   end
   assign oData_C = c[8];
endmodule

module FA (
   input  logic iA,
   input  logic iB,
   input  logic iC,
   output logic oS,
   output logic oC
);
   assign oS = iA ^ iB ^ iC;
   assign oC = (iA & iB) | (iC & (iA ^ iB));
endmodule
